// File: rtl/alu_issuer_pkg.sv
// Shared constants for the ALU issuer: ALU opcodes, FSM state encoding and
// the bit positions inside the normalised flag nibble.
package alu_issuer_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_EQ  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam int FLG_OUT   = 3;
  localparam int FLG_OVF   = 2;
  localparam int FLG_CARRY = 1;
  localparam int FLG_ZERO  = 0;

  // Compare opcodes report through alu_out only; their result/flags are don't-care.
  function automatic logic is_cmp(input logic [2:0] func);
    return (func == ALU_SLT) || (func == ALU_EQ);
  endfunction

endpackage

// File: rtl/alu_issuer_norm.sv
// Combinational normalisation of raw ALU outputs into {result, flags}.
// Zero is recomputed locally; carry/overflow survive only for add and sub.
module alu_issuer_norm
  import alu_issuer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   func_i,
  input  logic [W-1:0] alu_result_i,
  input  logic         alu_out_i,
  input  logic         alu_carry_i,
  input  logic         alu_overflow_i,
  output logic [W-1:0] result_o,
  output logic [3:0]   flags_o
);

  // NOTE: every output gets a default first so no path through the block can
  // leave a value unassigned and infer a latch.
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    if (is_cmp(func_i)) begin
      flags_o[FLG_OUT] = alu_out_i;
    end else begin
      result_o          = alu_result_i;
      flags_o[FLG_ZERO] = (alu_result_i == '0);
      if ((func_i == ALU_ADD) || (func_i == ALU_SUB)) begin
        flags_o[FLG_CARRY] = alu_carry_i;
        flags_o[FLG_OVF]   = alu_overflow_i;
      end
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// Sequential initiator for the 4-bit combinational ALU: request handshake,
// registered operands, one settle cycle, captured response, accumulator and
// saturating overflow counter.
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int           W       = 4,
  parameter int           CNT_W   = 8,
  parameter logic [W-1:0] ACC_RST = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_func,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic             req_use_acc,
  input  logic             req_wr_acc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_func,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [2:0]       alu_func_q, alu_func_d;
  logic             wr_acc_q, wr_acc_d;
  logic [W-1:0]     rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [W-1:0]     norm_result;
  logic [3:0]       norm_flags;

  // Zero is always recomputed from the result, so the ALU's own flag is ignored.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  alu_issuer_norm #(.W(W)) u_norm (
    .func_i         (alu_func_q),
    .alu_result_i   (alu_result),
    .alu_out_i      (alu_out),
    .alu_carry_i    (alu_carry),
    .alu_overflow_i (alu_overflow),
    .result_o       (norm_result),
    .flags_o        (norm_flags)
  );

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_func_d   = alu_func_q;
    wr_acc_d     = wr_acc_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    acc_d        = acc_q;
    ovf_cnt_d    = ovf_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_func_d = req_func;
          alu_a_d    = req_use_acc ? acc_q : req_a;
          alu_b_d    = req_b;
          wr_acc_d   = req_wr_acc;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        rsp_result_d = norm_result;
        rsp_flags_d  = norm_flags;
        if (wr_acc_q) begin
          acc_d = is_cmp(alu_func_q) ? {{(W-1){1'b0}}, norm_flags[FLG_OUT]} : norm_result;
        end
        if (norm_flags[FLG_OVF] && (ovf_cnt_q != '1)) begin
          ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_func_q   <= ALU_ADD;
      wr_acc_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      acc_q        <= ACC_RST;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_func_q   <= alu_func_d;
      wr_acc_q     <= wr_acc_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      acc_q        <= acc_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign acc        = acc_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_func   = alu_func_q;

endmodule

// File: doc/alu_issuer.md
# alu_issuer

Sequential initiator that drives the team's 4-bit combinational ALU port contract (operands A/B, 3-bit func; result, out, carry, zero, overflow). It accepts operation requests over a valid/ready handshake, registers the operands onto the ALU ports, waits one settle cycle, and captures and normalises the ALU outputs. It returns the result over a second valid/ready handshake. It also holds a 4-bit accumulator for chained operations and a saturating overflow counter for NPC bring-up tests.

## Interface
Parameters:
- W, 4, datapath width; only 4 is supported, matching the ALU.
- CNT_W, 8, width of the overflow event counter.
- ACC_RST, 4'h0, accumulator reset value.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request.
- req_func  in  3  ALU opcode: 0 add, 1 sub, 2 not A, 3 and, 4 or, 5 xor, 6 signed less-than, 7 equal.
- req_a, req_b  in  W  signed operands.
- req_use_acc  in  1  use the accumulator instead of req_a as operand A.
- req_wr_acc  in  1  write the normalised result into the accumulator.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  W  normalised result.
- rsp_flags  out  4  {out, overflow, carry, zero}.
- acc  out  W  current accumulator.
- ovf_cnt  out  CNT_W  count of responses with overflow=1; saturates.
- alu_a, alu_b  out  W  registered ALU operands.
- alu_func  out  3  registered ALU opcode.
- alu_result  in  W  ALU result.
- alu_out, alu_carry, alu_zero, alu_overflow  in  1  ALU status outputs.

## Operation
- FSM states are IDLE, DRIVE and RESP. Reset state is IDLE.
- IDLE: req_ready=1. When req_valid=1, the edge latches alu_func<=req_func, alu_a<=(req_use_acc ? acc : req_a), alu_b<=req_b, and the pending wr_acc bit, then moves to DRIVE.
- DRIVE: ALU ports are stable. The next edge captures the normalised outputs into the rsp_* registers and goes to RESP.
- RESP: rsp_valid=1. Outputs hold until rsp_ready=1. The handshake edge returns to IDLE.
- Normalisation for func 0–5:
  - rsp_result=alu_result and out=0.
  - carry and overflow come from the ALU for func 0/1 and are forced to 0 for func 2–5.
  - zero=(rsp_result==0), computed locally for every func.
- Normalisation for func 6/7:
  - rsp_result=0 and out=alu_out.
  - carry=0, overflow=0, zero=0.
  - The ALU result and flags for these funcs are don't-care and must never be sampled.
- Accumulator: when wr_acc is pending, it is written at the DRIVE→RESP edge with rsp_result (func 0–5) or {3'b0,out} (func 6/7).
- ovf_cnt increments at the DRIVE→RESP edge when the captured overflow=1. It holds at 2^CNT_W−1.
- alu_* outputs keep their last values in IDLE and RESP. They do not toggle.

## Timing
- Request accepted at edge E0. ALU inputs are valid in the cycle after E0. Capture happens at E1. rsp_valid=1 from E1 until the handshake edge.
- Minimum latency is 2 cycles from accept to response visible. Minimum throughput is one operation per 3 cycles.
- No request is accepted while a response is pending: req_ready=0 in DRIVE and RESP.
- Each rsp_* output is stable while rsp_valid=1 and rsp_ready=0.
- req_use_acc samples acc at E0, so a previous write is already visible (back-to-back chaining is safe).
- Reset values: req_ready=0 during reset and 1 after release; rsp_valid=0, rsp_result=0, rsp_flags=0, acc=ACC_RST, ovf_cnt=0, alu_a=0, alu_b=0, alu_func=0.
- Reset asserted mid-operation (DRIVE or RESP) immediately returns the FSM to IDLE. The pending response is discarded. The accumulator and counter take their reset values.

## Structure
- Shared package holds:
  - opcode constants (ALU_ADD…ALU_EQ);
  - FSM state encoding;
  - flag bit indices (FLG_OUT=3, FLG_OVF=2, FLG_CARRY=1, FLG_ZERO=0).
- One natural sub-module, alu_issuer_norm: purely combinational normalisation of {func, ALU outputs} into {result, flags}. The FSM, accumulator and counter stay in the top module.
- Benches connect the real ALU to the alu_* ports.

## Test plan
- Add: func 0, A=3, B=4 → rsp_result=7, flags 0000, response 2 cycles after accept.
- Subtract equal: func 1, A=5, B=5 → rsp_result=0, carry=1, zero=1, overflow=0.
- Overflow with chaining:
  - func 0, A=7, B=1, wr_acc=1 → rsp_result=4'b1000, overflow=1, ovf_cnt=1, acc=8.
  - Then func 0 with use_acc=1, B=1 → rsp_result=9.
- Compare: func 6, A=4'b1110 (−2), B=1 → out=1, rsp_result=0, other flags 0. Then func 7, A=B=5 → out=1.
- Backpressure: rsp_ready held 0 for 3 cycles → rsp_* stable, req_ready=0, and a req_valid pulse is not accepted. Release → IDLE on the next cycle.
- Reset in DRIVE: assert rst asynchronously → rsp_valid=0, acc=0, ovf_cnt=0 with no clock edge. After release, req_ready=1 and no stale response appears.
